regfile_wb_arbiter: RTL and testbench

Write-port arbiter for the 32x32 register file. It shares the file's single write port (RegWrite / WriteRegister / WriteData) among N_REQ writeback requesters, such as the ALU writeback, the load return and the multi-cycle multiply unit. Arbitration is round-robin, with a valid/ready handshake and a one-entry registered write stage. The block also bypasses the in-flight write onto both read ports, so a read in the same cycle as the write sees the new value. It sits between the pipeline's writeback sources and the register file.

---
 rtl/regfile_wb_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin register-file write-port arbiter with registered write stage and read bypass
module regfile_wb_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                freeze,
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  input  logic [AW-1:0]       rd_addr1,
  input  logic [AW-1:0]       rd_addr2,
  input  logic [DW-1:0]       rf_rdata1,
  input  logic [DW-1:0]       rf_rdata2,
  output logic [DW-1:0]       rd_data1,
  output logic [DW-1:0]       rd_data2,
  output logic [N_REQ-1:0]    last_grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Round-robin pointer: index where the next priority search begins.
  logic [PW-1:0]    ptr;

  logic [N_REQ-1:0] grantOneHot;
  logic [PW-1:0]    grantIdx;
  logic             grantFound;
  logic [AW-1:0]    selAddr;
  logic [DW-1:0]    selData;
  logic             xfer;

  // (base + offset) mod N_REQ without a divider; offset never exceeds N_REQ-1.
  function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return sum[PW-1:0];
  endfunction

  // Search upward from ptr for the first valid requester; no grant while frozen or in reset.
  always_comb begin
    grantOneHot = '0;
    grantIdx    = '0;
    grantFound  = 1'b0;
    if (!reset && !freeze) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grantFound && req_valid[wrapIdx(ptr, k)]) begin
          grantFound                   = 1'b1;
          grantIdx                     = wrapIdx(ptr, k);
          grantOneHot[wrapIdx(ptr, k)] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grantOneHot;

  // A grant is only ever given to a valid requester, so a grant is a transfer.
  assign xfer = grantFound;

  // One-hot mux picking the granted requester's address and data.
  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grantOneHot[i]) begin
        selAddr = req_addr[i*AW +: AW];
        selData = req_data[i*DW +: DW];
      end
    end
  end

  // Write stage and pointer: capture the winner, advance past it; idle cycles clear the enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= '0;
    end else if (xfer) begin
      ptr        <= wrapIdx(grantIdx, 1);
      rf_we      <= (selAddr != '0);
      rf_waddr   <= selAddr;
      rf_wdata   <= selData;
      last_grant <= grantOneHot;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Forward the in-flight write onto each read port; register 0 always reads raw.
  always_comb begin
    rd_data1 = rf_rdata1;
    rd_data2 = rf_rdata2;
    if (rf_we && (rd_addr1 != '0) && (rf_waddr == rd_addr1)) begin
      rd_data1 = rf_wdata;
    end
    if (rf_we && (rd_addr2 != '0) && (rf_waddr == rd_addr2)) begin
      rd_data2 = rf_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    reqValid;
  logic [N*AW-1:0] reqAddr;
  logic [N*DW-1:0] reqData;
  logic [N-1:0]    req_ready;
  logic            freeze;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [AW-1:0]   rdAddr1, rdAddr2;
  logic [DW-1:0]   rfRdata1, rfRdata2;
  logic [DW-1:0]   rd_data1, rd_data2;
  logic [N-1:0]    last_grant;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_addr(reqAddr), .req_data(reqData), .req_ready(req_ready),
    .freeze(freeze),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rdAddr1), .rd_addr2(rdAddr2),
    .rf_rdata1(rfRdata1), .rf_rdata2(rfRdata2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .last_grant(last_grant)
  );

  // Register file driven by the DUT's write port.
  logic [DW-1:0] rfMem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_we) rfMem[rf_waddr] <= rf_wdata;
  end

  int nVec = 0;
  int nMis = 0;

  // Reference model: pointer, pending write, and the register file contents.
  int            mPtr;
  logic          mWe;
  logic [AW-1:0] mWaddr;
  logic [DW-1:0] mWdata;
  logic [N-1:0]  mLast;
  logic [DW-1:0] mRf [32];

  typedef struct {
    logic [N-1:0]  valid;
    logic          frz;
    logic [N-1:0]  ready;
    logic          we;
    logic [AW-1:0] waddr;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[i]          = v;
    reqAddr[i*AW +: AW]  = a;
    reqData[i*DW +: DW]  = d;
  endtask

  function automatic int expGrant();
    if (freeze || reset) return -1;
    for (int k = 0; k < N; k++) begin
      if (reqValid[(mPtr + k) % N]) return (mPtr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] expRd(input logic [AW-1:0] a, input logic [DW-1:0] raw);
    if (mWe && (a != 0) && (mWaddr == a)) return mWdata;
    return raw;
  endfunction

  task automatic checkOutputs(input string tag);
    int g;
    logic [N-1:0] er;
    g  = expGrant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check({tag, ".ready"},  32'(req_ready),  32'(er));
    check({tag, ".we"},     32'(rf_we),      32'(mWe));
    check({tag, ".waddr"},  32'(rf_waddr),   32'(mWaddr));
    check({tag, ".wdata"},  rf_wdata,        mWdata);
    check({tag, ".last"},   32'(last_grant), 32'(mLast));
    check({tag, ".rd1"},    rd_data1,        expRd(rdAddr1, rfRdata1));
    check({tag, ".rd2"},    rd_data2,        expRd(rdAddr2, rfRdata2));
  endtask

  // Clock edge plus model update; returns the requester the model says transferred.
  task automatic advance(output int g);
    g = expGrant();
    @(posedge clk);
    if (mWe) mRf[mWaddr] = mWdata;
    if (g >= 0) begin
      mPtr   = (g + 1) % N;
      mWaddr = reqAddr[g*AW +: AW];
      mWdata = reqData[g*DW +: DW];
      mWe    = (reqAddr[g*AW +: AW] != 0);
      mLast  = '0;
      mLast[g] = 1'b1;
    end else begin
      mWe = 1'b0;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    mPtr = 0; mWe = 1'b0; mWaddr = '0; mWdata = '0; mLast = '0;
    for (int r = 0; r < 32; r++) mRf[r] = '0;

    tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b0, 5'd0};
    tbl[1]  = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd1};
    tbl[2]  = '{3'b111, 1'b0, 3'b100, 1'b1, 5'd2};
    tbl[3]  = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd3};
    tbl[4]  = '{3'b110, 1'b0, 3'b010, 1'b1, 5'd1};
    tbl[5]  = '{3'b110, 1'b0, 3'b100, 1'b1, 5'd2};
    tbl[6]  = '{3'b110, 1'b0, 3'b010, 1'b1, 5'd3};
    tbl[7]  = '{3'b110, 1'b0, 3'b100, 1'b1, 5'd2};
    tbl[8]  = '{3'b011, 1'b1, 3'b000, 1'b1, 5'd3};
    tbl[9]  = '{3'b011, 1'b1, 3'b000, 1'b0, 5'd3};
    tbl[10] = '{3'b011, 1'b1, 3'b000, 1'b0, 5'd3};
    tbl[11] = '{3'b011, 1'b0, 3'b001, 1'b0, 5'd3};
    tbl[12] = '{3'b011, 1'b0, 3'b010, 1'b1, 5'd1};
    tbl[13] = '{3'b000, 1'b0, 3'b000, 1'b1, 5'd2};
    tbl[14] = '{3'b000, 1'b0, 3'b000, 1'b0, 5'd2};

    // Reset state, with requests present.
    reset = 1'b1; freeze = 1'b0;
    reqValid = '0; reqAddr = '0; reqData = '0;
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    rdAddr1 = 5'd3; rdAddr2 = 5'd0; rfRdata1 = 32'h55; rfRdata2 = 32'h66;
    @(posedge clk); #1;
    check("rst.ready", 32'(req_ready), 32'h0);
    check("rst.we",    32'(rf_we),     32'h0);
    check("rst.waddr", 32'(rf_waddr),  32'h0);
    check("rst.wdata", rf_wdata,       32'h0);
    check("rst.last",  32'(last_grant), 32'h0);
    check("rst.rd1",   rd_data1,       32'h55);
    check("rst.rd2",   rd_data2,       32'h66);
    reset = 1'b0;

    // Round-robin / drop / freeze table, starting in the first cycle after reset.
    for (int v = 0; v < 15; v++) begin
      reqValid = tbl[v].valid;
      freeze   = tbl[v].frz;
      #1;
      check($sformatf("tbl%0d.ready", v), 32'(req_ready), 32'(tbl[v].ready));
      check($sformatf("tbl%0d.we", v),    32'(rf_we),     32'(tbl[v].we));
      check($sformatf("tbl%0d.waddr", v), 32'(rf_waddr),  32'(tbl[v].waddr));
      advance(g);
    end

    // Single request from requester 1.
    reqValid = '0;
    setReq(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1; check("single.ready", 32'(req_ready), 32'b010);
    advance(g); reqValid = '0;
    #1;
    check("single.we",    32'(rf_we),    32'h1);
    check("single.waddr", 32'(rf_waddr), 32'd5);
    check("single.wdata", rf_wdata,      32'hDEADBEEF);
    advance(g);
    #1; check("single.we_off", 32'(rf_we), 32'h0);

    // Register 0 write from requester 2 is accepted but dropped.
    setReq(2, 1'b1, 5'd0, 32'hFFFFFFFF);
    rdAddr1 = 5'd0; rfRdata1 = 32'h0BADF00D;
    #1; check("r0.ready", 32'(req_ready), 32'b100);
    advance(g); reqValid = '0;
    #1;
    check("r0.we",   32'(rf_we),      32'h0);
    check("r0.last", 32'(last_grant), 32'b100);
    check("r0.rd1",  rd_data1,        32'h0BADF00D);
    reqValid = 3'b111;
    #1; check("r0.ptr", 32'(req_ready), 32'b001);
    reqValid = '0;
    advance(g);
    #1; check("r0.we2", 32'(rf_we), 32'h0);

    // Bypass in the rf_we cycle.
    setReq(0, 1'b1, 5'd17, 32'h12345678);
    advance(g); reqValid = '0;
    rdAddr1 = 5'd17; rdAddr2 = 5'd18; rfRdata1 = 32'h0; rfRdata2 = 32'hAAAA;
    #1;
    check("byp.rd1", rd_data1, 32'h12345678);
    check("byp.rd2", rd_data2, 32'hAAAA);
    advance(g);
    #1;
    check("byp.rd1_after", rd_data1, 32'h0);

    // Randomized traffic against the model, register file fed from rfMem.
    reqValid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqValid[i] && ($urandom_range(0, 2) != 0))
          setReq(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      freeze  = ($urandom_range(0, 7) == 0);
      rdAddr1 = ($urandom_range(0, 1) == 1) ? mWaddr : 5'($urandom_range(0, 31));
      rdAddr2 = ($urandom_range(0, 1) == 1) ? mWaddr : 5'($urandom_range(0, 31));
      rfRdata1 = rfMem[rdAddr1];
      rfRdata2 = rfMem[rdAddr2];
      #1;
      checkOutputs($sformatf("rnd%0d", c));
      advance(g);
      if (g >= 0) reqValid[g] = 1'b0;
    end
    freeze = 1'b0; reqValid = '0;
    advance(g); advance(g);
    for (int r = 0; r < 32; r++) check($sformatf("rf[%0d]", r), rfMem[r], mRf[r]);

    // Reset while a write to register 9 is in flight.
    setReq(1, 1'b1, 5'd9, 32'hC0FFEE99);
    #1;
    g = expGrant();
    check("rstmid.grant", 32'(req_ready), (g >= 0) ? (32'h1 << g) : 32'h0);
    advance(g); reqValid = '0;
    #1;
    check("rstmid.we",    32'(rf_we),    32'h1);
    check("rstmid.waddr", 32'(rf_waddr), 32'd9);
    #2 reset = 1'b1;
    #1;
    check("rstmid.async_we", 32'(rf_we), 32'h0);
    mPtr = 0; mWe = 1'b0; mWaddr = '0; mWdata = '0; mLast = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 5'(i + 1), 32'h200 + 32'(i));
    #1;
    check("rstmid.ready", 32'(req_ready), 32'b001);
    check("rstmid.rf9",   rfMem[9],       mRf[9]);
    check("rstmid.waddr0", 32'(rf_waddr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
